ibex_mem_responder: RTL and testbench
=====================================

IBEX_MEM_RESPONDER -- requirements
Module: ibex_mem_responder

Interface
REQ-001 SHALL have parameter AddrBase, default 32'h8000_0000, base byte address of the responder window.
REQ-002 SHALL have parameter AddrMask, default 32'h0000_0FFF, window size minus one; Depth = (AddrMask+1)/4 words.
REQ-003 SHALL have parameter GntDelay, default 0, range 0..3, cycles req_i must be held before gnt_o.
REQ-004 SHALL have parameter RespLatency, default 1, range 1..4, cycles from grant cycle to rvalid_o.
REQ-005 SHALL have parameter MaxOutstanding, default 2, range 1..RespLatency, maximum granted-but-unanswered requests.
REQ-006 clk_i  input  1  single clock; all state on rising edge.
REQ-007 rst_i  input  1  reset, asynchronous assert, active-high.
REQ-008 req_i  input  1  host request valid; held with attributes until gnt_o.
REQ-009 addr_i  input  32  byte address; bits [1:0] ignored.
REQ-010 we_i  input  1  1 = write, 0 = read.
REQ-011 be_i  input  4  byte enables for writes.
REQ-012 wdata_i  input  32  write data.
REQ-013 gnt_o  output  1  request accepted this cycle.
REQ-014 rvalid_o  output  1  response valid, one cycle per granted request.
REQ-015 rdata_o  output  32  read data, valid with rvalid_o.
REQ-016 err_o  output  1  access error, valid with rvalid_o.
REQ-017 err_count_o  output  16  saturating count of error responses.

Function
REQ-018 SHALL treat a request as accepted in any cycle where req_i and gnt_o are both 1; at most one acceptance per cycle.
REQ-019 SHALL implement grant FSM IDLE/WAIT/GRANT: IDLE->WAIT on req_i with GntDelay>0; WAIT counts GntDelay cycles then ->GRANT; GRANT asserts gnt_o when not blocked, then ->IDLE or stays GRANT-ready for next request after a new delay count.
REQ-020 SHALL assert gnt_o combinationally in the first req_i cycle when GntDelay=0 and not blocked.
REQ-021 SHALL return FSM to IDLE and clear the delay count if req_i drops before grant.
REQ-022 SHALL block gnt_o when in-flight count equals MaxOutstanding, unless a response retires in that same cycle.
REQ-023 SHALL assert rvalid_o exactly RespLatency cycles after the accept cycle, in acceptance order.
REQ-024 SHALL classify address in range iff AddrBase <= addr_i <= AddrBase+AddrMask; word index = (addr_i-AddrBase)>>2.
REQ-025 SHALL perform an in-range write at the accept edge, updating only bytes with be_i set; be_i=0 leaves storage unchanged, no error.
REQ-026 SHALL sample in-range read data at the accept edge; a write accepted later is not visible in an earlier read's response.
REQ-027 SHALL respond to an out-of-range access with err_o=1, rdata_o=0, and no storage update.
REQ-028 SHALL drive rdata_o=0 for write responses and whenever rvalid_o=0.
REQ-029 SHALL increment err_count_o by one per error response, saturating at 16'hFFFF.
REQ-030 SHALL initialise storage to zero only at elaboration; reset SHALL NOT clear storage.

Reset
REQ-031 SHALL, while rst_i=1, drive gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, err_count_o=0, FSM=IDLE, in-flight count 0.
REQ-032 SHALL discard all in-flight responses when rst_i asserts mid-operation; no rvalid_o after release for pre-reset requests.
REQ-033 SHALL accept a new request in the first cycle after rst_i deasserts.

Verification
REQ-034 Defaults; write 32'hDEADBEEF be=4'hF at 32'h8000_0010, then read same -> gnt in request cycle, rvalid next cycle, rdata=32'hDEADBEEF, err=0.
REQ-035 Write 32'h1122_3344 be=4'b0101 over 32'hFFFF_FFFF at 32'h8000_0020, read -> rdata=32'hFF22_FF44.
REQ-036 Read 32'h8000_1000 and 32'h7FFF_FFFC -> two rvalids, err=1, rdata=0; err_count_o=2.
REQ-037 GntDelay=2, RespLatency=3, MaxOutstanding=2, req held continuously for 4 reads -> gnt 2 cycles after each new request, rvalid 3 cycles after each gnt, in-flight never exceeds 2.
REQ-038 RespLatency=4, two reads granted, rst_i pulsed 1 cycle before first response -> no rvalid_o after reset; next read granted first cycle after release.
REQ-039 Force 65,537 error responses -> err_count_o holds 16'hFFFF.

Source files
------------

// File: rtl/ibex_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : ibex_mem_responder
// Description : Ibex-style memory responder. It grants requests after a
//               configurable delay, answers each one after a fixed latency,
//               and serves a word-addressed storage window.
// Revision    : 1.0 - initial release
// ============================================================================
module ibex_mem_responder #(
    parameter logic [31:0] AddrBase       = 32'h8000_0000,
    parameter logic [31:0] AddrMask       = 32'h0000_0FFF,
    parameter int unsigned GntDelay       = 0,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [15:0] err_count_o
);

    localparam int unsigned c_DEPTH   = int'(AddrMask >> 2) + 1;
    localparam int unsigned c_IDX_W   = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
    localparam int unsigned c_LAST    = RespLatency - 1;
    localparam logic [2:0]  c_GNT_DLY = 3'(GntDelay);
    localparam logic [2:0]  c_MAX_OUT = 3'(MaxOutstanding);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2
    } state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [2:0]           r_cnt;
    logic [2:0]           w_cnt_next;
    logic                 w_gnt;
    logic                 w_accept;
    logic                 w_retire;
    logic                 w_blocked;
    logic                 w_in_range;
    logic [c_IDX_W-1:0]   w_idx;
    logic [2:0]           r_inflight;
    logic [15:0]          r_err_count;

    logic [RespLatency-1:0] r_vld;
    logic [RespLatency-1:0] r_err;
    logic [31:0]            r_rdata [RespLatency];

    // Storage is zero at elaboration and deliberately untouched by reset.
    logic [31:0] r_mem [c_DEPTH] = '{default: '0};

    assign w_in_range = ({1'b0, addr_i} >= {1'b0, AddrBase}) &&
                        ({1'b0, addr_i} <= ({1'b0, AddrBase} + {1'b0, AddrMask}));
    assign w_idx      = c_IDX_W'((addr_i - AddrBase) >> 2);

    assign w_retire   = r_vld[c_LAST];
    // A response leaving this cycle frees its slot for a same-cycle grant.
    assign w_blocked  = (r_inflight == c_MAX_OUT) && !w_retire;
    assign gnt_o      = w_gnt && !rst_i;
    assign w_accept   = req_i && gnt_o;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_gnt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    if (GntDelay == 0) begin
                        w_gnt = !w_blocked;
                    end else begin
                        w_cnt_next   = 3'd1;
                        w_state_next = (3'd1 >= c_GNT_DLY) ? S_GRANT : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!req_i) begin
                    w_cnt_next   = 3'd0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 3'd1;
                    if ((r_cnt + 3'd1) >= c_GNT_DLY) begin
                        w_state_next = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                if (!req_i) begin
                    w_cnt_next   = 3'd0;
                    w_state_next = S_IDLE;
                end else if (!w_blocked) begin
                    // Each following request restarts its own delay count.
                    w_gnt        = 1'b1;
                    w_cnt_next   = 3'd0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_cnt_next   = 3'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Response pipeline: read data is captured at the accept edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_err <= '0;
            for (int k = 0; k < RespLatency; k++) begin
                r_rdata[k] <= '0;
            end
        end else begin
            r_vld[0]   <= w_accept;
            r_err[0]   <= w_accept && !w_in_range;
            r_rdata[0] <= (w_accept && w_in_range && !we_i) ? r_mem[w_idx] : '0;
            for (int k = 1; k < RespLatency; k++) begin
                r_vld[k]   <= r_vld[k-1];
                r_err[k]   <= r_err[k-1];
                r_rdata[k] <= r_rdata[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inflight  <= 3'd0;
            r_err_count <= 16'd0;
        end else begin
            case ({w_accept, w_retire})
                2'b10:   r_inflight <= r_inflight + 3'd1;
                2'b01:   r_inflight <= r_inflight - 3'd1;
                default: r_inflight <= r_inflight;
            endcase
            if (w_retire && r_err[c_LAST] && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept && we_i && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o    = w_retire;
    assign err_o       = w_retire && r_err[c_LAST];
    assign rdata_o     = w_retire ? r_rdata[c_LAST] : 32'h0;
    assign err_count_o = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_ibex_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ibex_mem_responder
// Description : Directed bench for ibex_mem_responder in three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ibex_mem_responder;

    logic clk;
    logic rst;

    // Instance A: default parameters
    logic        req_a, we_a;
    logic [31:0] addr_a, wdata_a;
    logic [3:0]  be_a;
    logic        gnt_a, rvalid_a, err_a;
    logic [31:0] rdata_a;
    logic [15:0] cnt_a;

    // Instance B: GntDelay=2, RespLatency=3, MaxOutstanding=2
    logic        req_b, we_b;
    logic [31:0] addr_b, wdata_b;
    logic [3:0]  be_b;
    logic        gnt_b, rvalid_b, err_b;
    logic [31:0] rdata_b;
    logic [15:0] cnt_b;

    // Instance C: GntDelay=0, RespLatency=4, MaxOutstanding=2
    logic        req_c, we_c;
    logic [31:0] addr_c, wdata_c;
    logic [3:0]  be_c;
    logic        gnt_c, rvalid_c, err_c;
    logic [31:0] rdata_c;
    logic [15:0] cnt_c;

    ibex_mem_responder u_dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .addr_i(addr_a), .we_i(we_a),
        .be_i(be_a), .wdata_i(wdata_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
        .rdata_o(rdata_a), .err_o(err_a), .err_count_o(cnt_a)
    );

    ibex_mem_responder #(
        .GntDelay(2), .RespLatency(3), .MaxOutstanding(2)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .addr_i(addr_b), .we_i(we_b),
        .be_i(be_b), .wdata_i(wdata_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
        .rdata_o(rdata_b), .err_o(err_b), .err_count_o(cnt_b)
    );

    ibex_mem_responder #(
        .GntDelay(0), .RespLatency(4), .MaxOutstanding(2)
    ) u_dut_c (
        .clk_i(clk), .rst_i(rst), .req_i(req_c), .addr_i(addr_c), .we_i(we_c),
        .be_i(be_c), .wdata_i(wdata_c), .gnt_o(gnt_c), .rvalid_o(rvalid_c),
        .rdata_o(rdata_c), .err_o(err_c), .err_count_o(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[14];

    // Cycle-level monitor of instance B: grant/response cycle stamps.
    int tcyc = 0;
    int ng = 0;
    int nr = 0;
    int max_infl = 0;
    int gnt_t[8];
    int rv_t[8];
    int req_start[8];

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if ((ng - nr) > max_infl) max_infl = ng - nr;
            if (gnt_b && req_b && ng < 8) begin
                gnt_t[ng] = tcyc;
                ng++;
            end
            if (rvalid_b && nr < 8) begin
                rv_t[nr] = tcyc;
                nr++;
            end
        end
        tcyc++;
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'd0};
        vecs[1]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF, 16'd0};
        vecs[2]  = '{1'b1, 32'h8000_0020, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         16'd0};
        vecs[3]  = '{1'b1, 32'h8000_0020, 4'h5, 32'h1122_3344, 1'b0, 32'h0,         16'd0};
        vecs[4]  = '{1'b0, 32'h8000_0020, 4'h0, 32'h0,         1'b0, 32'hFF22_FF44, 16'd0};
        vecs[5]  = '{1'b0, 32'h8000_1000, 4'h0, 32'h0,         1'b1, 32'h0,         16'd1};
        vecs[6]  = '{1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,         1'b1, 32'h0,         16'd2};
        vecs[7]  = '{1'b1, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'h0,         16'd2};
        vecs[8]  = '{1'b0, 32'h8000_0010, 4'h0, 32'h0,         1'b0, 32'hDEAD_BEEF, 16'd2};
        vecs[9]  = '{1'b1, 32'h8000_1004, 4'hF, 32'h1234_5678, 1'b1, 32'h0,         16'd3};
        vecs[10] = '{1'b0, 32'h8000_0FFC, 4'h0, 32'h0,         1'b0, 32'h0,         16'd3};
        vecs[11] = '{1'b1, 32'h8000_0FFE, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0,         16'd3};
        vecs[12] = '{1'b0, 32'h8000_0FFC, 4'h0, 32'h0,         1'b0, 32'hCAFE_F00D, 16'd3};
        vecs[13] = '{1'b0, 32'h8000_0004, 4'h0, 32'h0,         1'b0, 32'h0,         16'd3};

        rst = 1'b1;
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h8000_0000; be_a = 4'h0; wdata_a = 32'h0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 32'h8000_0000; be_b = 4'h0; wdata_b = 32'h0;
        req_c = 1'b0; we_c = 1'b0; addr_c = 32'h8000_0000; be_c = 4'h0; wdata_c = 32'h0;

        // Outputs held quiet in reset even with a request pending
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gnt", 32'(gnt_a), 32'h0);
        chk("rst_rvalid", 32'(rvalid_a), 32'h0);
        chk("rst_rdata", rdata_a, 32'h0);
        chk("rst_err", 32'(err_a), 32'h0);
        chk("rst_cnt", 32'(cnt_a), 32'h0);

        // Release reset; first vector is presented in the first cycle after release
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            req_a = 1'b1; we_a = vecs[i].we; addr_a = vecs[i].addr;
            be_a = vecs[i].be; wdata_a = vecs[i].wdata;
            #1;
            chk($sformatf("v%0d_gnt", i), 32'(gnt_a), 32'h1);
            @(negedge clk);
            req_a = 1'b0;
            #1;
            chk($sformatf("v%0d_rvalid", i), 32'(rvalid_a), 32'h1);
            chk($sformatf("v%0d_err", i), 32'(err_a), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rdata", i), rdata_a, vecs[i].exp_rdata);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_idle_rvalid", i), 32'(rvalid_a), 32'h0);
            chk($sformatf("v%0d_idle_rdata", i), rdata_a, 32'h0);
            chk($sformatf("v%0d_cnt", i), 32'(cnt_a), 32'(vecs[i].exp_cnt));
        end

        // Instance B: req held for four reads, delayed grant and latency 3
        @(negedge clk);
        req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            int n;
            addr_b = 32'h8000_0000 + 32'(4 * k);
            req_start[k] = tcyc;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (ng <= k && n < 20);
            if (ng <= k) chk($sformatf("b_gnt%0d_timeout", k), 32'(ng), 32'(k + 1));
        end
        req_b = 1'b0;
        repeat (8) @(negedge clk);
        chk("b_ngnt", 32'(ng), 32'd4);
        chk("b_nrv", 32'(nr), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("b_gnt_delay%0d", k), 32'(gnt_t[k] - req_start[k]), 32'd2);
            chk($sformatf("b_rv_lat%0d", k), 32'(rv_t[k] - gnt_t[k]), 32'd3);
        end
        chk("b_max_inflight_le2", 32'(max_infl <= 2), 32'h1);

        // Instance C: in-flight limit blocks grant until a response retires
        req_c = 1'b1; addr_c = 32'h8000_0000;
        #1; chk("c_blk_gnt0", 32'(gnt_c), 32'h1);
        @(negedge clk); addr_c = 32'h8000_0004;
        #1; chk("c_blk_gnt1", 32'(gnt_c), 32'h1);
        @(negedge clk); addr_c = 32'h8000_0008;
        #1; chk("c_blk_gnt2", 32'(gnt_c), 32'h0);
        @(negedge clk);
        #1; chk("c_blk_gnt3", 32'(gnt_c), 32'h0);
        @(negedge clk);
        #1; chk("c_blk_rv4", 32'(rvalid_c), 32'h1);
        chk("c_blk_gnt4", 32'(gnt_c), 32'h1);
        @(negedge clk); req_c = 1'b0;
        #1; chk("c_blk_rv5", 32'(rvalid_c), 32'h1);
        @(negedge clk);
        #1; chk("c_blk_rv6", 32'(rvalid_c), 32'h0);
        repeat (2) @(negedge clk);
        #1; chk("c_blk_rv8", 32'(rvalid_c), 32'h1);
        repeat (3) @(negedge clk);

        // Instance C: reset one cycle before the first response
        req_c = 1'b1; addr_c = 32'h8000_0000;
        #1; chk("c_rst_gnt0", 32'(gnt_c), 32'h1);
        @(negedge clk); addr_c = 32'h8000_0004;
        #1; chk("c_rst_gnt1", 32'(gnt_c), 32'h1);
        @(negedge clk); req_c = 1'b0;
        @(negedge clk); rst = 1'b1; req_c = 1'b1;
        #1; chk("c_rst_rvalid", 32'(rvalid_c), 32'h0);
        chk("c_rst_gnt_gated", 32'(gnt_c), 32'h0);
        @(negedge clk); rst = 1'b0; addr_c = 32'h8000_0008;
        #1; chk("c_post_gnt", 32'(gnt_c), 32'h1);
        chk("c_post_rv4", 32'(rvalid_c), 32'h0);
        @(negedge clk); req_c = 1'b0;
        for (int j = 5; j < 8; j++) begin
            #1; chk($sformatf("c_post_rv%0d", j), 32'(rvalid_c), 32'h0);
            @(negedge clk);
        end
        #1; chk("c_post_rv8", 32'(rvalid_c), 32'h1);
        chk("c_post_err8", 32'(err_c), 32'h0);
        repeat (2) @(negedge clk);

        // Instance A: 65537 back-to-back error responses saturate the counter
        #1; chk("sat_start_cnt", 32'(cnt_a), 32'h0);
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h8000_2000; be_a = 4'h0;
        repeat (65535) @(negedge clk);
        #1; chk("sat_cnt_fffe", 32'(cnt_a), 32'h0000_FFFE);
        @(negedge clk);
        #1; chk("sat_cnt_ffff", 32'(cnt_a), 32'h0000_FFFF);
        @(negedge clk);
        req_a = 1'b0;
        repeat (3) @(negedge clk);
        #1; chk("sat_cnt_hold", 32'(cnt_a), 32'h0000_FFFF);
        chk("sat_rvalid_idle", 32'(rvalid_a), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
